nco_sine: RTL

- Numerically controlled oscillator stage directly downstream of the chirp controller.
- Consumes `nco_reset` and the 32-bit phase increment `nco_control`, and accumulates phase.
- Converts phase to a signed sine sample through a pipelined quarter-wave ROM.
- Output feeds the DAC/sample path.

---
 rtl/nco_sine.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/nco_sine.sv
//-----------------------------------------------------------------------------
// nco_sine
//
// Numerically controlled oscillator feeding the DAC sample path. A phase
// accumulator advances by nco_control every clock. The top phase bits are
// turned into a signed sine sample through a quarter-wave ROM. There are four
// register stages: accumulate, quadrant decode, ROM read, and sign/mute. A
// phase registered at edge n therefore reaches sine_out at edge n+3. The
// block accepts one sample per clock and never stalls.
//
// The quarter-wave table holds
//   rom[k] = round((2^(OUT_W-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_AW)).
// The table is built at elaboration by a constant function, so no external
// init file is needed. The half-LSB offset keeps the table symmetric under
// bitwise address mirroring.
//
// Optional build macro: NCO_COS_EN
//   When defined, the block adds a cosine_out port. It uses a second ROM read
//   port with quadrant q+1. The cosine path has the same latency as the sine
//   path and shares out_valid with it.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset, clears every register
//   nco_reset    in   synchronous phase clear and output mute
//   nco_control  in   unsigned phase increment per clock (PHASE_W)
//   sine_out     out  signed sine sample (OUT_W)
//   cosine_out   out  signed cosine sample (OUT_W), NCO_COS_EN builds only
//   out_valid    out  sine_out/cosine_out carry a valid sample
//-----------------------------------------------------------------------------
module nco_sine #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 10,
   parameter int OUT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     nco_reset,
   input  logic [PHASE_W-1:0]       nco_control,
   output logic signed [OUT_W-1:0]  sine_out,
`ifdef NCO_COS_EN
   output logic signed [OUT_W-1:0]  cosine_out,
`endif
   output logic                     out_valid
);

   localparam int ROM_DEPTH = 1 << LUT_AW;
   localparam int MAG_W     = OUT_W - 1;

   // Fixed-point scaling for the elaboration-time sine evaluation.
   // Q.60 with 128-bit intermediates keeps the rounding error far below the
   // half-LSB decision point of any OUT_W up to 32.
   localparam int                  FRAC_W     = 60;
   localparam int                  TAYLOR_N   = 14;
   localparam logic signed [127:0] PI_HALF_FX = 128'sh1921_FB54_442D_1846;
   localparam logic signed [127:0] AMP_FX     = (128'sd1 <<< MAG_W) - 128'sd1;
   localparam logic signed [127:0] HALF_FX    = 128'sd1 <<< (FRAC_W - 1);

   // Table entry k, evaluated at elaboration time only.
   // The Taylor series for sin() converges quickly for x <= pi/2.
   function automatic logic [MAG_W-1:0] rom_entry(input int k);
      logic signed [127:0] x;
      logic signed [127:0] x2;
      logic signed [127:0] term;
      logic signed [127:0] acc;
      logic signed [127:0] scaled;
      x    = (PI_HALF_FX * 128'(2 * k + 1)) >>> (LUT_AW + 1);
      x2   = (x * x) >>> FRAC_W;
      term = x;
      acc  = x;
      for (int n = 1; n <= TAYLOR_N; n++) begin
         term = -((term * x2) >>> FRAC_W) / 128'(2 * n * (2 * n + 1));
         acc  = acc + term;
      end
      scaled = (acc * AMP_FX + HALF_FX) >>> FRAC_W;
      return MAG_W'(scaled);
   endfunction

   // Constant quarter-wave table. Reading it through a register lets
   // synthesis map it onto block RAM.
   logic [MAG_W-1:0] w_rom [ROM_DEPTH];

   for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
      localparam logic [MAG_W-1:0] ENTRY = rom_entry(k);
      assign w_rom[k] = ENTRY;
   end

   // Stage registers
   logic [PHASE_W-1:0] r_phase;
   logic               r_vld0;
   logic [LUT_AW-1:0]  r_addr;
   logic               r_neg1;
   logic               r_vld1;
   logic [MAG_W-1:0]   r_mag;
   logic               r_neg2;
   logic               r_vld2;

   // Quadrant and in-quadrant address, taken from the accumulator.
   // The phase bits below the ROM address are truncated without rounding.
   logic [1:0]              w_quad;
   logic [LUT_AW-1:0]       w_frac;
   logic signed [OUT_W-1:0] w_mag_s;

   assign w_quad  = r_phase[PHASE_W-1 -: 2];
   assign w_frac  = r_phase[PHASE_W-3 -: LUT_AW];
   assign w_mag_s = {1'b0, r_mag};

   if (PHASE_W - 2 > LUT_AW) begin : g_lsb
      logic w_unused_phase_lsbs;
      assign w_unused_phase_lsbs = ^r_phase[PHASE_W-3-LUT_AW:0];
   end

   // NOTE: sequential state uses non-blocking assignments so that every
   // stage samples the previous stage's value from before this edge.
   // NOTE: the ROM array is a constant and holds no state, so it has no
   // reset. Only the stage registers around it are cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase   <= '0;
         r_vld0    <= 1'b0;
         r_addr    <= '0;
         r_neg1    <= 1'b0;
         r_vld1    <= 1'b0;
         r_mag     <= '0;
         r_neg2    <= 1'b0;
         r_vld2    <= 1'b0;
         sine_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         // Stage 0: accumulate, or pin phase to 0 and mute while nco_reset is high.
         if (nco_reset) begin
            r_phase <= '0;
            r_vld0  <= 1'b0;
         end else begin
            r_phase <= r_phase + nco_control;
            r_vld0  <= 1'b1;
         end

         // Stage 1: quadrants 1 and 3 read the table backwards.
         // Quadrants 2 and 3 are negative.
         r_addr <= w_quad[0] ? ~w_frac : w_frac;
         r_neg1 <= w_quad[1];
         r_vld1 <= r_vld0;

         // Stage 2: synchronous ROM read.
         r_mag  <= w_rom[r_addr];
         r_neg2 <= r_neg1;
         r_vld2 <= r_vld1;

         // Stage 3: apply sign, or force zero on a muted slot. mag never
         // exceeds 2^(OUT_W-1)-1, so its negation always fits in OUT_W bits.
         sine_out  <= r_vld2 ? (r_neg2 ? -w_mag_s : w_mag_s) : '0;
         out_valid <= r_vld2;
      end
   end

`ifdef NCO_COS_EN
   // Cosine path: quadrant qc = q + 1 (mod 4).
   // qc[0] = ~q[0] selects mirroring, and qc[1] = q[1] ^ q[0] gives the sign.
   logic [LUT_AW-1:0]       r_addr_c;
   logic                    r_neg1_c;
   logic [MAG_W-1:0]        r_mag_c;
   logic                    r_neg2_c;
   logic signed [OUT_W-1:0] w_mag_c_s;

   assign w_mag_c_s = {1'b0, r_mag_c};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_c   <= '0;
         r_neg1_c   <= 1'b0;
         r_mag_c    <= '0;
         r_neg2_c   <= 1'b0;
         cosine_out <= '0;
      end else begin
         r_addr_c   <= w_quad[0] ? w_frac : ~w_frac;
         r_neg1_c   <= w_quad[1] ^ w_quad[0];
         r_mag_c    <= w_rom[r_addr_c];
         r_neg2_c   <= r_neg1_c;
         cosine_out <= r_vld2 ? (r_neg2_c ? -w_mag_c_s : w_mag_c_s) : '0;
      end
   end
`endif

endmodule
